// File: rtl/sort4_cmp_ctrl_pkg.sv
// Shared types and constants for the four-operand sequential bubble sorter.
// The swap rule lives here so the top and any checker agree on stability.
package sort4_cmp_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int         NUM_OPS   = 4;
  localparam logic [1:0] LAST_PASS = 2'd2;

  // Equal operands never swap, which keeps the sort stable.
  function automatic logic swap_req(input logic eq, input logic gt, input logic lt,
                                    input logic ascend);
    if (eq) begin
      swap_req = 1'b0;
    end else if (ascend) begin
      swap_req = gt;
    end else begin
      swap_req = lt;
    end
  endfunction

endpackage

// File: rtl/sort4_cmp_ctrl_if.sv
// Request/result bundle between the operand source and the sorter.
interface sort4_cmp_ctrl_if #(parameter int W = 3);

  logic         start;
  logic [W-1:0] din0, din1, din2, din3;
  logic         busy;
  logic         done;
  logic [W-1:0] dout0, dout1, dout2, dout3;
  logic [2:0]   swaps;

  modport master (
    output start, din0, din1, din2, din3,
    input  busy, done, dout0, dout1, dout2, dout3, swaps
  );

  modport slave (
    input  start, din0, din1, din2, din3,
    output busy, done, dout0, dout1, dout2, dout3, swaps
  );

endinterface

// File: rtl/mag_cmp3.sv
// Combinational W-bit unsigned magnitude comparator shared by every sort step.
module mag_cmp3 #(
  parameter int W = 3
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         eq,
  output logic         gt,
  output logic         lt
);

  assign eq = (a == b);
  assign gt = (a > b);
  assign lt = (a < b);

endmodule

// File: rtl/sort4_cmp_ctrl.sv
// Sorts four W-bit operands in six fixed compare/swap steps using one comparator.
// Results and swap count are published together on the edge that enters DONE.
module sort4_cmp_ctrl
  import sort4_cmp_ctrl_pkg::*;
#(
  parameter int W      = 3,
  parameter bit ASCEND = 1'b1
) (
  input logic              clk,
  input logic              rst_n,
  sort4_cmp_ctrl_if.slave  bus
);

  state_e       state_r, state_nxt_s;
  logic [W-1:0] r_r     [NUM_OPS];
  logic [W-1:0] r_nxt_s [NUM_OPS];
  logic [W-1:0] dout_r  [NUM_OPS];
  logic [W-1:0] a_s, b_s;
  logic [1:0]   pass_r, idx_r, idx_hi_s, last_idx_s;
  logic [2:0]   swap_cnt_r, swap_cnt_nxt_s, swaps_r;
  logic         busy_r, done_r, busy_nxt_s, done_nxt_s;
  logic         eq_s, gt_s, lt_s, swap_s, last_idx_hit_s, last_step_s;

  assign idx_hi_s       = idx_r + 2'd1;
  assign a_s            = r_r[idx_r];
  assign b_s            = r_r[idx_hi_s];
  assign last_idx_s     = LAST_PASS - pass_r;
  assign last_idx_hit_s = (idx_r == last_idx_s);
  assign last_step_s    = last_idx_hit_s && (pass_r == LAST_PASS);
  assign swap_s         = (state_r == CMP) && swap_req(eq_s, gt_s, lt_s, ASCEND);

  mag_cmp3 #(.W(W)) u_cmp (
    .a  (a_s),
    .b  (b_s),
    .eq (eq_s),
    .gt (gt_s),
    .lt (lt_s)
  );

  // State register plus registered busy/done decoded from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      busy_r  <= busy_nxt_s;
      done_r  <= done_nxt_s;
    end
  end

  // Next-state logic: fixed six-step schedule, no early exit.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE:    state_nxt_s = bus.start ? CMP : IDLE;
      CMP:     state_nxt_s = last_step_s ? DONE : CMP;
      DONE:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Output decode for the registered status flags.
  always_comb begin
    busy_nxt_s = (state_nxt_s == CMP);
    done_nxt_s = (state_nxt_s == DONE);
  end

  // Swap write-back candidate for the current step.
  always_comb begin
    for (int i = 0; i < NUM_OPS; i++) begin
      r_nxt_s[i] = r_r[i];
    end
    if (swap_s) begin
      r_nxt_s[idx_r]    = b_s;
      r_nxt_s[idx_hi_s] = a_s;
    end else begin
      r_nxt_s[idx_r]    = a_s;
    end
    swap_cnt_nxt_s = swap_cnt_r + {2'b00, swap_s};
  end

  // Operand storage, step indices and published result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_OPS; i++) begin
        r_r[i]    <= {W{1'b0}};
        dout_r[i] <= {W{1'b0}};
      end
      pass_r     <= 2'd0;
      idx_r      <= 2'd0;
      swap_cnt_r <= 3'd0;
      swaps_r    <= 3'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.start) begin
            r_r[0]     <= bus.din0;
            r_r[1]     <= bus.din1;
            r_r[2]     <= bus.din2;
            r_r[3]     <= bus.din3;
            pass_r     <= 2'd0;
            idx_r      <= 2'd0;
            swap_cnt_r <= 3'd0;
          end else begin
            swap_cnt_r <= swap_cnt_r;
          end
        end
        CMP: begin
          r_r        <= r_nxt_s;
          swap_cnt_r <= swap_cnt_nxt_s;
          if (!last_idx_hit_s) begin
            idx_r <= idx_r + 2'd1;
          end else if (pass_r != LAST_PASS) begin
            pass_r <= pass_r + 2'd1;
            idx_r  <= 2'd0;
          end else begin
            dout_r  <= r_nxt_s;
            swaps_r <= swap_cnt_nxt_s;
          end
        end
        default: begin
          swap_cnt_r <= swap_cnt_r;
        end
      endcase
    end
  end

  assign bus.busy  = busy_r;
  assign bus.done  = done_r;
  assign bus.dout0 = dout_r[0];
  assign bus.dout1 = dout_r[1];
  assign bus.dout2 = dout_r[2];
  assign bus.dout3 = dout_r[3];
  assign bus.swaps = swaps_r;

endmodule

// File: tb/tb_sort4_cmp_ctrl.sv
// Self-checking bench: ascending and descending sorters driven in parallel and
// compared against a counting-sort / inversion-count reference model.
module tb_sort4_cmp_ctrl;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  sort4_cmp_ctrl_if #(.W(3)) bus_a ();
  sort4_cmp_ctrl_if #(.W(3)) bus_d ();

  sort4_cmp_ctrl #(.W(3), .ASCEND(1'b1)) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
  sort4_cmp_ctrl #(.W(3), .ASCEND(1'b0)) dut_d (.clk(clk), .rst_n(rst_n), .bus(bus_d));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input int d[4], input logic st);
    bus_a.start = st; bus_d.start = st;
    bus_a.din0 = 3'(d[0]); bus_a.din1 = 3'(d[1]); bus_a.din2 = 3'(d[2]); bus_a.din3 = 3'(d[3]);
    bus_d.din0 = 3'(d[0]); bus_d.din1 = 3'(d[1]); bus_d.din2 = 3'(d[2]); bus_d.din3 = 3'(d[3]);
  endtask

  // Reference: counting sort for the order, inversion count for the swaps.
  task automatic ref_sort(input int d[4], input bit asc, output int s[4], output int sw);
    int cnt[8];
    int k;
    for (int v = 0; v < 8; v++) cnt[v] = 0;
    for (int i = 0; i < 4; i++) cnt[d[i]]++;
    k = 0;
    for (int v = 0; v < 8; v++) begin
      int val;
      val = asc ? v : 7 - v;
      for (int n = 0; n < cnt[val]; n++) begin
        s[k] = val;
        k++;
      end
    end
    sw = 0;
    for (int i = 0; i < 4; i++)
      for (int j = i + 1; j < 4; j++)
        if (asc ? (d[i] > d[j]) : (d[i] < d[j])) sw++;
  endtask

  task automatic check_outputs(input string tag, input int d[4]);
    int s[4];
    int sw;
    ref_sort(d, 1'b1, s, sw);
    check({tag, "_a_dout0"}, 32'(bus_a.dout0), s[0]);
    check({tag, "_a_dout1"}, 32'(bus_a.dout1), s[1]);
    check({tag, "_a_dout2"}, 32'(bus_a.dout2), s[2]);
    check({tag, "_a_dout3"}, 32'(bus_a.dout3), s[3]);
    check({tag, "_a_swaps"}, 32'(bus_a.swaps), sw);
    ref_sort(d, 1'b0, s, sw);
    check({tag, "_d_dout0"}, 32'(bus_d.dout0), s[0]);
    check({tag, "_d_dout1"}, 32'(bus_d.dout1), s[1]);
    check({tag, "_d_dout2"}, 32'(bus_d.dout2), s[2]);
    check({tag, "_d_dout3"}, 32'(bus_d.dout3), s[3]);
    check({tag, "_d_swaps"}, 32'(bus_d.swaps), sw);
  endtask

  task automatic check_flags(input string tag, input logic busy_exp, input logic done_exp);
    check({tag, "_a_busy"}, 32'(bus_a.busy), 32'(busy_exp));
    check({tag, "_a_done"}, 32'(bus_a.done), 32'(done_exp));
    check({tag, "_d_busy"}, 32'(bus_d.busy), 32'(busy_exp));
    check({tag, "_d_done"}, 32'(bus_d.done), 32'(done_exp));
  endtask

  // One complete sort with the fixed 6-cycle busy / 1-cycle done timing.
  task automatic run_sort(input string tag, input int d[4], input bit inject);
    int junk[4];
    junk = '{3, 3, 3, 3};
    @(negedge clk); drive(d, 1'b1);
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (c == 1) drive(d, 1'b0);
      if (inject && c == 3) drive(junk, 1'b1);
      if (inject && c == 4) drive(junk, 1'b0);
      check_flags($sformatf("%s_c%0d", tag, c), 1'b1, 1'b0);
    end
    @(negedge clk);
    check_flags({tag, "_done"}, 1'b0, 1'b1);
    check_outputs(tag, d);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      check_flags({tag, "_after"}, 1'b0, 1'b0);
      check_outputs({tag, "_hold"}, d);
    end
  endtask

  initial begin
    int d[4];
    int first_a, second_a, first_d, second_d;
    d = '{0, 0, 0, 0};
    drive(d, 1'b0);
    #2;
    check_flags("reset", 1'b0, 1'b0);
    check_outputs("reset", d);
    @(negedge clk); rst_n = 1'b1;

    d = '{7, 5, 3, 1}; run_sort("rev", d, 1'b0);
    d = '{0, 2, 4, 6}; run_sort("fwd", d, 1'b0);
    d = '{1, 6, 0, 6}; run_sort("eq6", d, 1'b0);
    d = '{5, 5, 5, 5}; run_sort("fives", d, 1'b1);

    // Reset during the third compare cycle.
    d = '{7, 5, 3, 1};
    @(negedge clk); drive(d, 1'b1);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      if (c == 1) drive(d, 1'b0);
    end
    rst_n = 1'b0;
    #1;
    check_flags("midrst", 1'b0, 1'b0);
    d = '{0, 0, 0, 0};
    check_outputs("midrst", d);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check_flags("midrst_hold", 1'b0, 1'b0);
    end
    rst_n = 1'b1;
    d = '{2, 0, 1, 3}; run_sort("after_rst", d, 1'b0);

    // Start held high: back-to-back sorts, done pulses 8 cycles apart.
    d = '{4, 1, 0, 0};
    first_a = -1; second_a = -1; first_d = -1; second_d = -1;
    @(negedge clk); drive(d, 1'b1);
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      if (bus_a.done) begin
        if (first_a < 0) first_a = cyc; else if (second_a < 0) second_a = cyc;
      end
      if (bus_d.done) begin
        if (first_d < 0) first_d = cyc; else if (second_d < 0) second_d = cyc;
      end
      if (first_a >= 0 && first_d >= 0) check_outputs("held_stable", d);
      if (second_a >= 0 && second_d >= 0) break;
    end
    check("held_first_found", 32'(first_a >= 0 && first_d >= 0), 32'd1);
    check("held_gap_a", 32'(second_a - first_a), 32'd8);
    check("held_gap_d", 32'(second_d - first_d), 32'd8);
    drive(d, 1'b0);
    for (int c = 0; c < 4; c++) @(negedge clk);
    check_flags("held_idle", 1'b0, 1'b0);

    for (int t = 0; t < 24; t++) begin
      for (int i = 0; i < 4; i++) d[i] = int'($urandom_range(0, 7));
      run_sort($sformatf("rnd%0d", t), d, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
